// File: rtl/tinyalu_pkg.sv
// -----------------------------------------------------------------------------
// tinyalu_pkg
//   Shared TinyALU types: the ALU opcode enum plus the arbiter FSM state,
//   the result returned on aborted/illegal operations, and an opcode helper.
// -----------------------------------------------------------------------------
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESPOND
    } arb_state_t;

    localparam logic [15:0] ARB_ERR_RESULT = 16'h0000;

    // True only for opcodes that actually need the ALU datapath.
    function automatic logic is_alu_op(input logic [2:0] op);
        case (op)
            add_op, and_op, xor_op, mul_op: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tinyalu_rr_pick.sv
// -----------------------------------------------------------------------------
// tinyalu_rr_pick
//   Combinational round-robin picker: the winner is the first set bit of req
//   at or above rr_ptr, wrapping modulo N_REQ.
//   Ports:
//     req    in  N_REQ  request levels
//     rr_ptr in  IDX_W  highest-priority index
//     win    out IDX_W  winning index (0 when none)
//     any    out 1      at least one request present
// -----------------------------------------------------------------------------
module tinyalu_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] win,
    output logic             any
);

    int off;
    int best;

    // Each requester's distance from rr_ptr (mod N_REQ); smallest distance wins.
    always_comb begin
        win  = '0;
        any  = 1'b0;
        best = N_REQ;
        off  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            off = i - int'(rr_ptr);
            if (off < 0) off = off + N_REQ;
            if (req[i] && (off < best)) begin
                best = off;
                win  = IDX_W'(i);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tinyalu_arbiter.sv
// -----------------------------------------------------------------------------
// tinyalu_arbiter
//   Shares one TinyALU among N_REQ requesters. Round-robin grant, start/done
//   sequencing, no_op/rst_op filtering, and a done-timeout watchdog.
//   Ports:
//     clk, reset_n              clock, async active-low reset
//     req/req_a/req_b/req_op    per-requester request level and operands
//     resp_valid                one-hot single-cycle response strobe
//     resp_result, resp_err     response payload
//     alu_start/alu_a/alu_b/alu_op, alu_done/alu_result   TinyALU side
//   All outputs are registered.
// -----------------------------------------------------------------------------
module tinyalu_arbiter
    import tinyalu_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0][7:0] req_a,
    input  logic [N_REQ-1:0][7:0] req_b,
    input  logic [N_REQ-1:0][2:0] req_op,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [15:0]           resp_result,
    output logic                  resp_err,
    output logic                  alu_start,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output operation_t            alu_op,
    input  logic                  alu_done,
    input  logic [15:0]           alu_result
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] g_idx;
    logic [WD_W-1:0]  wd_cnt;

    logic [IDX_W-1:0] win;
    logic             any;
    logic [2:0]       sel_op;

    tinyalu_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .win    (win),
        .any    (any)
    );

    assign sel_op = req_op[win];

    // The alu_a/alu_b/alu_op registers double as the latched operands: they
    // are loaded only for real ALU ops, so no_op/rst_op leave the ALU untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            g_idx       <= '0;
            wd_cnt      <= '0;
            resp_valid  <= '0;
            resp_result <= '0;
            resp_err    <= 1'b0;
            alu_start   <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= no_op;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        g_idx <= win;
                        if (is_alu_op(sel_op)) begin
                            state     <= ISSUE;
                            alu_start <= 1'b1;
                            alu_a     <= req_a[win];
                            alu_b     <= req_b[win];
                            alu_op    <= operation_t'(sel_op);
                            wd_cnt    <= '0;
                        end else begin
                            // Filtered locally: respond straight away.
                            state       <= RESPOND;
                            resp_valid  <= N_REQ'(1) << win;
                            resp_result <= ARB_ERR_RESULT;
                            resp_err    <= (sel_op != no_op);
                        end
                    end
                end
                ISSUE: begin
                    // A done arriving on the last watchdog cycle still wins.
                    if (alu_done) begin
                        state       <= RESPOND;
                        alu_start   <= 1'b0;
                        resp_valid  <= N_REQ'(1) << g_idx;
                        resp_result <= alu_result;
                        resp_err    <= 1'b0;
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        state       <= RESPOND;
                        alu_start   <= 1'b0;
                        resp_valid  <= N_REQ'(1) << g_idx;
                        resp_result <= ARB_ERR_RESULT;
                        resp_err    <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                RESPOND: begin
                    // RESPOND plus the following IDLE cycle keep alu_start low
                    // for at least two cycles between operations.
                    state       <= IDLE;
                    resp_valid  <= '0;
                    resp_result <= '0;
                    resp_err    <= 1'b0;
                    wd_cnt      <= '0;
                    rr_ptr      <= (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + IDX_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tinyalu_arbiter
//   Directed scoreboard bench: stimulus pushes hand-computed expected responses
//   into a queue; a monitor pops and compares on every resp_valid.
// -----------------------------------------------------------------------------
module tb_tinyalu_arbiter;
    import tinyalu_pkg::*;

    localparam int N   = 4;
    localparam int TO  = 16;
    localparam int LAT = 3;   // done is raised in the 4th start cycle

    typedef struct {
        int          idx;
        logic [15:0] res;
        logic        err;
    } exp_t;

    logic                clk;
    logic                reset_n;
    logic [N-1:0]        req;
    logic [N-1:0][7:0]   req_a;
    logic [N-1:0][7:0]   req_b;
    logic [N-1:0][2:0]   req_op;
    logic [N-1:0]        resp_valid;
    logic [15:0]         resp_result;
    logic                resp_err;
    logic                alu_start;
    logic [7:0]          alu_a;
    logic [7:0]          alu_b;
    operation_t          alu_op;
    logic                alu_done;
    logic [15:0]         alu_result;

    logic                model_done;
    logic [15:0]         model_result;
    int                  model_cnt;
    logic                withhold;
    logic                inj;

    exp_t                q[$];
    int                  checks;
    int                  failures;
    int                  resp_count;
    int                  cur_run, last_run, runs_seen;
    int                  low_run, last_gap;

    tinyalu_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .alu_start   (alu_start),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_done    (alu_done),
        .alu_result  (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple TinyALU stand-in: fixed latency, optional done withholding.
    assign alu_done   = model_done | inj;
    assign alu_result = model_result;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_done   <= 1'b0;
            model_result <= '0;
            model_cnt    <= 0;
        end else if (model_done) begin
            model_done <= 1'b0;
            model_cnt  <= 0;
        end else if (alu_start && !withhold) begin
            if (model_cnt == LAT - 1) begin
                model_done <= 1'b1;
                case (alu_op)
                    add_op:  model_result <= {8'h00, alu_a} + {8'h00, alu_b};
                    and_op:  model_result <= {8'h00, alu_a & alu_b};
                    xor_op:  model_result <= {8'h00, alu_a ^ alu_b};
                    mul_op:  model_result <= alu_a * alu_b;
                    default: model_result <= 16'hDEAD;
                endcase
            end else begin
                model_cnt <= model_cnt + 1;
            end
        end else begin
            model_cnt <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic raise(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req_a[i]  = a;
        req_b[i]  = b;
        req_op[i] = op;
        req[i]    = 1'b1;
    endtask

    task automatic push(input int i, input logic [15:0] r, input logic e);
        exp_t x;
        x.idx = i;
        x.res = r;
        x.err = e;
        q.push_back(x);
    endtask

    task automatic wait_resp(input int i, input int budget);
        bit got;
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (resp_valid[i]) begin
                req[i] = 1'b0;
                got = 1'b1;
            end
        end
        if (!got) check("resp_wait_timeout", 32'(i), 32'hFFFF_FFFF);
    endtask

    task automatic wait_mask(input logic [N-1:0] mask, input int budget);
        logic [N-1:0] served;
        served = '0;
        for (int c = 0; c < budget && served != mask; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (resp_valid[i]) begin
                    req[i] = 1'b0;
                    served[i] = 1'b1;
                end
        end
        check("mask_served", 32'(served), 32'(mask));
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && resp_valid != '0) begin
            resp_count++;
            check("resp_onehot", 32'($onehot(resp_valid)), 32'd1);
            if (q.size() == 0) begin
                check("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("resp_idx", 32'(resp_valid), 32'd1 << e.idx);
                check("resp_result", 32'(resp_result), 32'(e.res));
                check("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    // alu_start high-run and low-gap trackers.
    always @(negedge clk) begin
        if (alu_start) begin
            cur_run++;
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end else begin
            low_run++;
            if (cur_run != 0) begin
                last_run = cur_run;
                runs_seen++;
                cur_run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int rs, rc, n_resp;
        bit rereq_pending, rereq_done;

        checks = 0; failures = 0; resp_count = 0;
        cur_run = 0; last_run = 0; runs_seen = 0; low_run = 0; last_gap = 0;
        req = '0; req_a = '0; req_b = '0; req_op = '0;
        withhold = 1'b0; inj = 1'b0;
        reset_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'(no_op));
        check("rst_result", 32'(resp_result), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // All four simultaneously, rr_ptr=0; requester 0 re-requests after its response
        push(0, 16'h0100, 1'b0);
        push(1, 16'h0030, 1'b0);
        push(2, 16'h00FF, 1'b0);
        push(3, 16'h0005, 1'b0);
        raise(0, 8'h10, 8'h10, mul_op);
        raise(1, 8'hF0, 8'h3C, and_op);
        raise(2, 8'hAA, 8'h55, xor_op);
        raise(3, 8'h02, 8'h03, add_op);
        n_resp = 0; rereq_pending = 0; rereq_done = 0;
        for (int c = 0; c < 200 && n_resp < 5; c++) begin
            @(negedge clk);
            if (rereq_pending) begin
                raise(0, 8'h01, 8'h01, add_op);
                push(0, 16'h0002, 1'b0);
                rereq_pending = 0;
            end
            for (int i = 0; i < N; i++)
                if (resp_valid[i]) begin
                    req[i] = 1'b0;
                    n_resp++;
                    if (i == 0 && !rereq_done) begin
                        rereq_done = 1;
                        rereq_pending = 1;
                    end
                end
        end
        check("rr_resp_count", 32'(n_resp), 32'd5);
        repeat (2) @(negedge clk);

        // Single add with carry out; operands held during ISSUE
        push(0, 16'h0100, 1'b0);
        raise(0, 8'hFF, 8'h01, add_op);
        repeat (2) @(negedge clk);
        check("issue_start", 32'(alu_start), 32'd1);
        check("issue_a", 32'(alu_a), 32'hFF);
        check("issue_b", 32'(alu_b), 32'h01);
        check("issue_op", 32'(alu_op), 32'(add_op));
        wait_resp(0, 30);
        repeat (2) @(negedge clk);
        check("add_start_run", 32'(last_run), 32'd4);

        // no_op then rst_op on requester 2: immediate response, ALU untouched
        rs = runs_seen;
        push(2, 16'h0000, 1'b0);
        raise(2, 8'h12, 8'h34, no_op);
        @(posedge clk); @(negedge clk);
        check("noop_latency", 32'(resp_valid), 32'b0100);
        req[2] = 1'b0;
        @(negedge clk);
        push(2, 16'h0000, 1'b1);
        raise(2, 8'h56, 8'h78, rst_op);
        @(posedge clk); @(negedge clk);
        check("rstop_latency", 32'(resp_valid), 32'b0100);
        req[2] = 1'b0;
        repeat (3) @(negedge clk);
        check("filter_no_start", 32'(runs_seen), 32'(rs));

        // Watchdog timeout on requester 1, then a late done is ignored
        withhold = 1'b1;
        push(1, 16'h0000, 1'b1);
        raise(1, 8'h05, 8'h06, mul_op);
        wait_resp(1, 60);
        repeat (2) @(negedge clk);
        check("timeout_start_run", 32'(last_run), 32'd16);
        rc = resp_count;
        rs = runs_seen;
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        repeat (5) @(negedge clk);
        check("late_done_no_resp", 32'(resp_count), 32'(rc));
        check("late_done_no_start", 32'(runs_seen), 32'(rs));
        withhold = 1'b0;

        // Reset mid-mul (rr_ptr is 2 here), then 1 and 3 together: reset scan picks 1
        raise(3, 8'h10, 8'h10, mul_op);
        repeat (2) @(negedge clk);
        check("mul_started", 32'(alu_start), 32'd1);
        reset_n = 1'b0;
        req[3] = 1'b0;
        #1;
        check("async_rst_start", 32'(alu_start), 32'd0);
        check("async_rst_a", 32'(alu_a), 32'd0);
        check("async_rst_b", 32'(alu_b), 32'd0);
        check("async_rst_op", 32'(alu_op), 32'(no_op));
        check("async_rst_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push(1, 16'h000D, 1'b0);
        push(3, 16'h0100, 1'b0);
        raise(1, 8'h07, 8'h06, add_op);
        raise(3, 8'h10, 8'h10, mul_op);
        wait_mask(4'b1010, 60);
        repeat (2) @(negedge clk);

        // Back-to-back xor from requester 0
        push(0, 16'h00A5, 1'b0);
        raise(0, 8'hAA, 8'h0F, xor_op);
        wait_resp(0, 30);
        @(negedge clk);
        push(0, 16'h00CC, 1'b0);
        raise(0, 8'h33, 8'hFF, xor_op);
        wait_resp(0, 30);
        repeat (2) @(negedge clk);
        check("b2b_gap_ge2", 32'(last_gap >= 2), 32'd1);

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tinyalu_arbiter.md
# tinyalu_arbiter

Shares one TinyALU among `N_REQ` independent requesters. Each requester presents a request with operands A, B and an `operation_t` opcode. The arbiter grants requests round-robin, sequences the ALU's start/done handshake, and returns the 16-bit result to the granted requester. It sits between the requester-side logic and the TinyALU ports, and adds `no_op`/`rst_op` filtering plus a done-timeout watchdog.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 16: maximum cycles in ISSUE without `alu_done` before abort, ≥ 4.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level.
- `req_a`  in  N_REQ×8  operand A per requester.
- `req_b`  in  N_REQ×8  operand B per requester.
- `req_op`  in  N_REQ×3  `operation_t` per requester.
- `resp_valid`  out  N_REQ  one-hot, one-cycle response strobe.
- `resp_result`  out  16  result, valid with `resp_valid`.
- `resp_err`  out  1  error flag, valid with `resp_valid`.
- `alu_start`  out  1  TinyALU start.
- `alu_a`, `alu_b`  out  8  TinyALU operands.
- `alu_op`  out  3  TinyALU opcode.
- `alu_done`  in  1  TinyALU done pulse.
- `alu_result`  in  16  TinyALU result.

## Operation
- Requester protocol:
  - Requester raises `req[i]` with operands stable.
  - It holds `req[i]` and operands until it sees `resp_valid[i]`.
  - It may re-raise `req[i]` in the cycle after the response.
- States: IDLE, ISSUE, RESPOND.
- IDLE, any `req` set:
  - Pick winner `g` = first set bit at or above `rr_ptr`, wrapping modulo `N_REQ`.
  - Latch `g` and its A/B/op into internal registers.
  - Opcode `add_op`/`and_op`/`xor_op`/`mul_op`: go to ISSUE.
  - Opcode `no_op`: go to RESPOND with result 0, err 0, ALU untouched.
  - Opcode `rst_op` or any undefined encoding: go to RESPOND with result 0, err 1, ALU untouched.
- ISSUE:
  - `alu_start`=1; `alu_a`/`alu_b`/`alu_op` driven from the latched registers and held constant.
  - Watchdog counter runs from 0.
  - `alu_done`=1: capture `alu_result`, go to RESPOND with err 0.
  - Counter reaches `TIMEOUT`-1 with no done: go to RESPOND with result 0, err 1.
- RESPOND:
  - `resp_valid[g]`=1 for exactly one cycle, with `resp_result`/`resp_err`.
  - `rr_ptr` ← (g+1) mod `N_REQ`.
  - Go to IDLE.
- The arbiter never rechecks `req[g]` after grant. A requester dropping `req` early is a protocol violation; the response is still issued.
- `alu_done` outside ISSUE is ignored.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - state IDLE, `rr_ptr`=0, watchdog counter 0.
  - `resp_valid`=0, `resp_result`=0, `resp_err`=0.
  - `alu_start`=0, `alu_a`=0, `alu_b`=0, `alu_op`=`no_op`.
- Reset mid-operation aborts with no response. Requesters must re-request.
- All outputs are registered.
- Grant edge → `alu_start` high in the next cycle.
- Edge sampling `alu_done`=1 → `alu_start` low and `resp_valid` high in the following cycle.
- The ALU is started the cycle after grant. The response appears one cycle after done. The minimum total overhead beyond ALU latency is 2 cycles.
- `no_op`/illegal opcode: request sampled at edge T → `resp_valid` during cycle T+1.
- RESPOND→IDLE guarantees `alu_start` is low for at least 2 cycles between consecutive operations, so the ALU never sees back-to-back start.
- Throughput with all requesters busy: one operation per (ALU latency + 3) cycles.
- Fairness: with all `N_REQ` requesting continuously, each requester is served exactly once per `N_REQ` operations.
- Timeout abort drops `alu_start` in the RESPOND cycle. A late `alu_done` arriving later is ignored.

## Structure
- `operation_t` already exists in `tinyalu_pkg`; reuse it.
- Add to `tinyalu_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, RESPOND}.
  - `logic [15:0]` localparam `ARB_ERR_RESULT` = 0.
- One sub-module, `tinyalu_rr_pick`:
  - Combinational round-robin picker.
  - Inputs: `req` vector and `rr_ptr`.
  - Outputs: winner index and `any` flag.
- The FSM, watchdog counter and operand registers live in `tinyalu_arbiter`.

## Test plan
- Single requester 0, `add_op`, A=8'hFF, B=8'h01 → `alu_start` held until done; `resp_valid`=4'b0001, `resp_result`=16'h0100, err 0.
- All four requesters raise simultaneously: `mul_op` 8'h10×8'h10, `and_op` 8'hF0&8'h3C, `xor_op` 8'hAA^8'h55, `add_op` 8'h02+8'h03.
  - Responses arrive in order 0,1,2,3 with results 16'h0100, 16'h0030, 16'h00FF, 16'h0005.
  - Requester 0 re-requesting is next served after requester 3.
- Requester 2 issues `no_op`, then `rst_op` → `alu_start` never asserts; responses one cycle after grant with result 0; err 0 for `no_op`, then err 1 for `rst_op`.
- ALU model withholds `alu_done`, `TIMEOUT`=16 → `alu_start` drops after 16 ISSUE cycles; `resp_err`=1, `resp_result`=0. A done pulse injected later produces no response.
- `reset_n` pulsed low mid-`mul_op` → all outputs zero immediately (asynchronous). After release, a fresh request to requester 1 is granted first (`rr_ptr`=0 scan) and completes normally.
- Back-to-back `xor_op` from one requester → `alu_start` low for at least 2 cycles between operations; both results correct.
